// File: rtl/ahb_timer_if.sv
// ahb_timer_if: AHB3-Lite slave port bundle (select, address/control, data, handshake)
interface ahb_timer_if;
  logic        s_hsel_i;
  logic [31:0] s_haddr_i;
  logic [1:0]  s_htrans_i;
  logic        s_hwrite_i;
  logic [2:0]  s_hsize_i;
  logic [31:0] s_hwdata_i;
  logic [31:0] s_hrdata_o;
  logic        s_hready_o;
  logic        s_hresp_o;
  modport master (
    output s_hsel_i, s_haddr_i, s_htrans_i, s_hwrite_i, s_hsize_i, s_hwdata_i,
    input  s_hrdata_o, s_hready_o, s_hresp_o
  );
  modport slave (
    input  s_hsel_i, s_haddr_i, s_htrans_i, s_hwrite_i, s_hsize_i, s_hwdata_i,
    output s_hrdata_o, s_hready_o, s_hresp_o
  );
endinterface

// File: rtl/ahb_timer.sv
// ahb_timer: AHB3-Lite 64-bit prescaled timer with compare and level interrupt
module ahb_timer #(
  parameter int          PRESC_W = 16,
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic       s_clk_i,
  input  logic       s_resetn_i,
  ahb_timer_if.slave bus,
  output logic       s_irq_o
);
  typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;
  state_t             r_state;
  logic               r_dp_rd, r_dp_wr, r_hready, r_hresp;
  logic [2:0]         r_dp_off;
  logic               r_en, r_ie, r_pend, r_irq;
  logic [PRESC_W-1:0] r_presc, r_pcnt;
  logic [63:0]        r_time, r_cmp;
  logic               w_accept, w_legal, w_tick, w_pend_nxt, w_ie_nxt;
  logic [63:0]        w_time_inc;
  logic [31:0]        w_wdata, w_rdata;
  logic               w_wr_ctrl, w_wr_presc, w_wr_tlo, w_wr_thi, w_wr_clo, w_wr_chi, w_wr_stat;
  // Address phases arriving while the first error cycle is on the bus are dropped
  assign w_accept   = bus.s_hsel_i & bus.s_htrans_i[1] & (r_state != ERR1);
  assign w_legal    = (bus.s_hsize_i == 3'b010) && (bus.s_haddr_i[1:0] == 2'b00) && (bus.s_haddr_i[4:2] != 3'd7);
  assign w_tick     = r_en & (r_pcnt == r_presc);
  assign w_time_inc = r_time + 64'd1;
  assign w_wdata    = bus.s_hwdata_i;
  assign w_wr_ctrl  = r_dp_wr & (r_dp_off == 3'd0);
  assign w_wr_presc = r_dp_wr & (r_dp_off == 3'd1);
  assign w_wr_tlo   = r_dp_wr & (r_dp_off == 3'd2);
  assign w_wr_thi   = r_dp_wr & (r_dp_off == 3'd3);
  assign w_wr_clo   = r_dp_wr & (r_dp_off == 3'd4);
  assign w_wr_chi   = r_dp_wr & (r_dp_off == 3'd5);
  assign w_wr_stat  = r_dp_wr & (r_dp_off == 3'd6);
  // A set from the compare beats a same-cycle W1C; irq tracks the next IE/PEND so it lands with them
  assign w_pend_nxt = (r_time >= r_cmp) | (r_pend & ~(w_wr_stat & w_wdata[0]));
  assign w_ie_nxt   = w_wr_ctrl ? w_wdata[1] : r_ie;
  // Bus FSM: captures the data-phase intent and sequences the two-cycle ERROR response
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      r_state  <= IDLE;
      r_dp_rd  <= 1'b0;
      r_dp_wr  <= 1'b0;
      r_dp_off <= 3'd0;
      r_hready <= 1'b1;
      r_hresp  <= 1'b0;
    end else begin
      r_dp_rd  <= w_accept & w_legal & ~bus.s_hwrite_i;
      r_dp_wr  <= w_accept & w_legal & bus.s_hwrite_i;
      r_dp_off <= bus.s_haddr_i[4:2];
      if (w_accept && !w_legal) begin
        r_state  <= ERR1;
        r_hready <= 1'b0;
        r_hresp  <= 1'b1;
      end else if (r_state == ERR1) begin
        r_state  <= ERR2;
        r_hready <= 1'b1;
        r_hresp  <= 1'b1;
      end else begin
        r_state  <= IDLE;
        r_hready <= 1'b1;
        r_hresp  <= 1'b0;
      end
    end
  end
  // Read mux from live register values so a read right after a write sees the new data
  always_comb begin
    w_rdata = 32'd0;
    case (r_dp_off)
      3'd0:    w_rdata = {30'd0, r_ie, r_en};
      3'd1:    w_rdata = 32'(r_presc);
      3'd2:    w_rdata = r_time[31:0];
      3'd3:    w_rdata = r_time[63:32];
      3'd4:    w_rdata = r_cmp[31:0];
      3'd5:    w_rdata = r_cmp[63:32];
      3'd6:    w_rdata = {31'd0, r_pend};
      default: w_rdata = 32'd0;
    endcase
  end
  assign bus.s_hrdata_o = r_dp_rd ? w_rdata : 32'd0;
  assign bus.s_hready_o = r_hready;
  assign bus.s_hresp_o  = r_hresp;
  assign s_irq_o        = r_irq;
  // Timer datapath: register writes, prescaler, 64-bit time counter, compare pending and irq
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      r_en    <= 1'b0;
      r_ie    <= 1'b0;
      r_presc <= '0;
      r_pcnt  <= '0;
      r_time  <= 64'd0;
      r_cmp   <= CMP_RST;
      r_pend  <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr_ctrl) {r_ie, r_en} <= w_wdata[1:0];
      if (w_wr_presc) r_presc <= w_wdata[PRESC_W-1:0];
      r_pcnt <= w_wr_presc ? '0 : !r_en ? r_pcnt : w_tick ? '0 : r_pcnt + 1'b1;
      if (w_wr_tlo) r_time[31:0] <= w_wdata;
      else if (w_wr_thi) r_time <= {w_wdata, w_tick ? w_time_inc[31:0] : r_time[31:0]};
      else if (w_tick) r_time <= w_time_inc;
      if (w_wr_clo) r_cmp[31:0] <= w_wdata;
      if (w_wr_chi) r_cmp[63:32] <= w_wdata;
      r_pend <= w_pend_nxt;
      r_irq  <= w_ie_nxt & w_pend_nxt;
    end
  end
endmodule

// File: tb/tb_ahb_timer.sv
// tb_ahb_timer: directed self-checking bench for the AHB timer
module tb_ahb_timer;
  localparam logic [31:0] A_CTRL = 32'h00, A_PRESC = 32'h04, A_TLO = 32'h08, A_THI = 32'h0C;
  localparam logic [31:0] A_CLO = 32'h10, A_CHI = 32'h14, A_STAT = 32'h18;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;
  logic [31:0] d;
  logic rdy, rsp;
  int total = 0;
  int bad = 0;
  ahb_timer_if bus();
  ahb_timer #(.PRESC_W(16), .CMP_RST(64'hFFFF_FFFF_FFFF_FFFF)) dut (
    .s_clk_i(clk), .s_resetn_i(rst_n), .bus(bus.slave), .s_irq_o(irq)
  );
  always #5 clk = ~clk;
  task automatic cyc(input logic v, input logic w, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    @(posedge clk);
    #1;
    bus.s_hsel_i   = v;
    bus.s_htrans_i = v ? 2'b10 : 2'b00;
    bus.s_hwrite_i = w;
    bus.s_haddr_i  = a;
    bus.s_hsize_i  = sz;
    bus.s_hwdata_i = wd;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] wd);
    cyc(1'b1, 1'b1, a, 3'd2, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 3'd2, wd);
  endtask
  task automatic rd(input logic [31:0] a);
    cyc(1'b1, 1'b0, a, 3'd2, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 3'd2, 32'd0);
    @(negedge clk);
    d = bus.s_hrdata_o; rdy = bus.s_hready_o; rsp = bus.s_hresp_o;
  endtask
  task automatic sample;
    @(negedge clk);
    d = bus.s_hrdata_o; rdy = bus.s_hready_o; rsp = bus.s_hresp_o;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    bus.s_hsel_i = 1'b0; bus.s_htrans_i = 2'b00; bus.s_hwrite_i = 1'b0;
    bus.s_haddr_i = 32'd0; bus.s_hsize_i = 3'd2; bus.s_hwdata_i = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic test_reset;
    logic [31:0] ra [5];
    logic [31:0] re [5];
    ra = '{A_CTRL, A_PRESC, A_TLO, A_CLO, A_CHI};
    re = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    do_reset;
    sample;
    total++; if ({rdy, rsp, d, irq} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin bad++; $display("FAIL reset_outputs got rdy=%b rsp=%b rdata=%h irq=%b exp 1 0 0 0", rdy, rsp, d, irq); end
    for (int i = 0; i < 5; i++) begin
      rd(ra[i]);
      total++; if (d !== re[i]) begin bad++; $display("FAIL reset_reg%0d got=%h exp=%h", i, d, re[i]); end
    end
  endtask
  task automatic test_ctrl;
    wr(A_CTRL, 32'h3);
    rd(A_CTRL);
    total++; if ({rdy, rsp, d} !== {1'b1, 1'b0, 32'h3}) begin bad++; $display("FAIL ctrl_rw got rdy=%b rsp=%b rdata=%h exp 1 0 3", rdy, rsp, d); end
    wr(A_CTRL, 32'hFFFF_FFFF);
    rd(A_CTRL);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL ctrl_mask got=%h exp=3", d); end
    wr(A_CTRL, 32'h0);
  endtask
  task automatic test_back_to_back;
    do_reset;
    cyc(1'b1, 1'b1, A_PRESC, 3'd2, 32'd0);
    cyc(1'b1, 1'b0, A_PRESC, 3'd2, 32'h1234_5678);
    cyc(1'b1, 1'b1, A_CLO, 3'd2, 32'd0);
    sample;
    total++; if ({rdy, rsp, d} !== {1'b1, 1'b0, 32'h5678}) begin bad++; $display("FAIL b2b_presc got rdy=%b rsp=%b rdata=%h exp 1 0 5678", rdy, rsp, d); end
    cyc(1'b1, 1'b0, A_CLO, 3'd2, 32'hA5A5_0001);
    sample;
    total++; if (d !== 32'd0) begin bad++; $display("FAIL b2b_wr_rdata got=%h exp=0", d); end
    cyc(1'b0, 1'b0, 32'd0, 3'd2, 32'd0);
    sample;
    total++; if (d !== 32'hA5A5_0001) begin bad++; $display("FAIL b2b_cmp got=%h exp=a5a50001", d); end
  endtask
  task automatic test_prescaler;
    do_reset;
    wr(A_PRESC, 32'd3);
    wr(A_CTRL, 32'd1);
    repeat (40) @(posedge clk);
    rd(A_TLO);
    total++; if (d !== 32'd10) begin bad++; $display("FAIL presc_count got=%0d exp=10", d); end
    wr(A_CTRL, 32'd0);
    repeat (20) @(posedge clk);
    rd(A_TLO);
    total++; if (d !== 32'd11) begin bad++; $display("FAIL presc_hold got=%0d exp=11", d); end
  endtask
  task automatic test_carry;
    do_reset;
    wr(A_TLO, 32'hFFFF_FFFF);
    cyc(1'b1, 1'b1, A_CTRL, 3'd2, 32'd0);
    cyc(1'b1, 1'b0, A_THI, 3'd2, 32'd1);
    cyc(1'b1, 1'b0, A_TLO, 3'd2, 32'd0);
    sample;
    total++; if (d !== 32'd0) begin bad++; $display("FAIL carry_hi0 got=%h exp=0", d); end
    cyc(1'b1, 1'b0, A_THI, 3'd2, 32'd0);
    sample;
    total++; if (d !== 32'd0) begin bad++; $display("FAIL carry_lo got=%h exp=0", d); end
    cyc(1'b0, 1'b0, 32'd0, 3'd2, 32'd0);
    sample;
    total++; if (d !== 32'd1) begin bad++; $display("FAIL carry_hi1 got=%h exp=1", d); end
  endtask
  task automatic test_wrap_and_tick_writes;
    do_reset;
    wr(A_TLO, 32'hFFFF_FFFF);
    wr(A_THI, 32'hFFFF_FFFF);
    cyc(1'b1, 1'b1, A_CTRL, 3'd2, 32'd0);
    cyc(1'b1, 1'b0, A_THI, 3'd2, 32'd1);
    cyc(1'b1, 1'b0, A_TLO, 3'd2, 32'd0);
    sample;
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_hi_pre got=%h exp=ffffffff", d); end
    cyc(1'b1, 1'b0, A_THI, 3'd2, 32'd0);
    sample;
    total++; if (d !== 32'd0) begin bad++; $display("FAIL wrap_lo got=%h exp=0", d); end
    cyc(1'b0, 1'b0, 32'd0, 3'd2, 32'd0);
    sample;
    total++; if (d !== 32'd0) begin bad++; $display("FAIL wrap_hi got=%h exp=0", d); end
    cyc(1'b1, 1'b1, A_THI, 3'd2, 32'd0);
    cyc(1'b1, 1'b0, A_TLO, 3'd2, 32'h55);
    cyc(1'b1, 1'b0, A_THI, 3'd2, 32'd0);
    sample;
    total++; if (d !== 32'd4) begin bad++; $display("FAIL thi_tick_lo got=%0d exp=4", d); end
    cyc(1'b1, 1'b1, A_TLO, 3'd2, 32'd0);
    sample;
    total++; if (d !== 32'h55) begin bad++; $display("FAIL thi_tick_hi got=%h exp=55", d); end
    cyc(1'b1, 1'b0, A_TLO, 3'd2, 32'h100);
    cyc(1'b0, 1'b0, 32'd0, 3'd2, 32'd0);
    sample;
    total++; if (d !== 32'h100) begin bad++; $display("FAIL tlo_tick_lost got=%h exp=100", d); end
  endtask
  task automatic test_compare;
    int n;
    do_reset;
    wr(A_CLO, 32'd50);
    wr(A_CHI, 32'd0);
    wr(A_TLO, 32'd49);
    rd(A_STAT);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL cmp_below got=%h exp=0", d); end
    wr(A_TLO, 32'd50);
    rd(A_STAT);
    total++; if ({d, irq} !== {32'd1, 1'b0}) begin bad++; $display("FAIL cmp_equal got pend=%h irq=%b exp 1 0", d, irq); end
    wr(A_TLO, 32'd0);
    wr(A_STAT, 32'd1);
    rd(A_STAT);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL w1c_clear got=%h exp=0", d); end
    wr(A_CTRL, 32'd3);
    n = 0;
    for (int i = 1; i <= 100 && n == 0; i++) begin
      @(posedge clk);
      #1;
      if (irq) n = i;
    end
    total++; if (n < 52 || n > 53) begin bad++; $display("FAIL irq_rise got edge=%0d exp 52..53 (0=timeout)", n); end
    wr(A_STAT, 32'd1);
    rd(A_STAT);
    total++; if ({d, irq} !== {32'd1, 1'b1}) begin bad++; $display("FAIL set_wins got pend=%h irq=%b exp 1 1", d, irq); end
    wr(A_CHI, 32'hFFFF_FFFF);
    wr(A_CLO, 32'hFFFF_FFFF);
    wr(A_STAT, 32'd1);
    rd(A_STAT);
    total++; if ({d, irq} !== {32'd0, 1'b0}) begin bad++; $display("FAIL irq_clear got pend=%h irq=%b exp 0 0", d, irq); end
  endtask
  task automatic test_illegal;
    logic [31:0] ia [3];
    logic [2:0]  iz [3];
    logic        iw [3];
    ia = '{A_PRESC, 32'h1C, 32'h02};
    iz = '{3'd0, 3'd2, 3'd2};
    iw = '{1'b1, 1'b0, 1'b0};
    do_reset;
    wr(A_PRESC, 32'd5);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, iw[i], ia[i], iz[i], 32'd0);
      cyc(1'b0, 1'b0, 32'd0, 3'd2, 32'h77);
      sample;
      total++; if ({rdy, rsp, d} !== {1'b0, 1'b1, 32'd0}) begin bad++; $display("FAIL err1_%0d got rdy=%b rsp=%b rdata=%h exp 0 1 0", i, rdy, rsp, d); end
      cyc(1'b0, 1'b0, 32'd0, 3'd2, 32'h77);
      sample;
      total++; if ({rdy, rsp, d} !== {1'b1, 1'b1, 32'd0}) begin bad++; $display("FAIL err2_%0d got rdy=%b rsp=%b rdata=%h exp 1 1 0", i, rdy, rsp, d); end
      rd(A_PRESC);
      total++; if ({rdy, rsp, d} !== {1'b1, 1'b0, 32'd5}) begin bad++; $display("FAIL err_unchanged_%0d got rdy=%b rsp=%b rdata=%h exp 1 0 5", i, rdy, rsp, d); end
    end
    cyc(1'b1, 1'b0, 32'h1C, 3'd2, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 3'd2, 32'd0);
    cyc(1'b1, 1'b0, A_PRESC, 3'd2, 32'd0);
    sample;
    total++; if ({rdy, rsp} !== 2'b11) begin bad++; $display("FAIL err2_accept_phase got rdy=%b rsp=%b exp 1 1", rdy, rsp); end
    cyc(1'b0, 1'b0, 32'd0, 3'd2, 32'd0);
    sample;
    total++; if ({rdy, rsp, d} !== {1'b1, 1'b0, 32'd5}) begin bad++; $display("FAIL err2_read got rdy=%b rsp=%b rdata=%h exp 1 0 5", rdy, rsp, d); end
    cyc(1'b1, 1'b0, 32'h1C, 3'd2, 32'd0);
    cyc(1'b1, 1'b1, A_PRESC, 3'd2, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 3'd2, 32'd9);
    cyc(1'b0, 1'b0, 32'd0, 3'd2, 32'd9);
    sample;
    total++; if ({rdy, rsp} !== 2'b10) begin bad++; $display("FAIL err1_ignore_resp got rdy=%b rsp=%b exp 1 0", rdy, rsp); end
    rd(A_PRESC);
    total++; if (d !== 32'd5) begin bad++; $display("FAIL err1_ignore_presc got=%h exp=5", d); end
  endtask
  task automatic test_async_reset;
    do_reset;
    wr(A_CLO, 32'd0);
    wr(A_CHI, 32'd0);
    wr(A_TLO, 32'h77);
    wr(A_CTRL, 32'd2);
    cyc(1'b0, 1'b0, 32'd0, 3'd2, 32'd0);
    sample;
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL pre_reset_irq got=%b exp=1", irq); end
    cyc(1'b1, 1'b0, 32'h1C, 3'd2, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 3'd2, 32'd0);
    sample;
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL pre_reset_err1 got rdy=%b exp=0", rdy); end
    #1 rst_n = 1'b0;
    #1;
    total++; if ({bus.s_hready_o, bus.s_hresp_o, bus.s_hrdata_o, irq} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin bad++; $display("FAIL async_rst_err1 got rdy=%b rsp=%b rdata=%h irq=%b exp 1 0 0 0", bus.s_hready_o, bus.s_hresp_o, bus.s_hrdata_o, irq); end
    bus.s_hsel_i = 1'b0; bus.s_htrans_i = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    rd(A_TLO);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL async_rst_time got=%h exp=0", d); end
    rd(A_CLO);
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL async_rst_cmp got=%h exp=ffffffff", d); end
    wr(A_CHI, 32'd0);
    wr(A_CLO, 32'd0);
    wr(A_TLO, 32'd5);
    wr(A_CTRL, 32'd2);
    cyc(1'b1, 1'b1, A_THI, 3'd2, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 3'd2, 32'hABCD);
    sample;
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL pre_reset_irq2 got=%b exp=1", irq); end
    #1 rst_n = 1'b0;
    #1;
    total++; if ({bus.s_hready_o, bus.s_hresp_o, irq} !== {1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL async_rst_wr got rdy=%b rsp=%b irq=%b exp 1 0 0", bus.s_hready_o, bus.s_hresp_o, irq); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    rd(A_THI);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL async_rst_thi got=%h exp=0", d); end
    rd(A_TLO);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL async_rst_tlo got=%h exp=0", d); end
    rd(A_CHI);
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL async_rst_chi got=%h exp=ffffffff", d); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_ctrl;
    test_back_to_back;
    test_prescaler;
    test_carry;
    test_wrap_and_tick_writes;
    test_compare;
    test_illegal;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
